// File: rtl/alu_op_sequencer.sv
// Control stage in front of a combinational 16-bit ALU: one instruction per 4 cycles, small register file.
// Optional condition flags are built only when ALU_SEQ_FLAGS_EN is defined; otherwise the flags are tied to 0.
module alu_op_sequencer #(
  parameter int WIDTH = 16,
  parameter int NREGS = 4,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic             in_use_imm,
  input  logic [WIDTH-1:0] in_imm,
  input  logic [AW-1:0]    in_rs1,
  input  logic [AW-1:0]    in_rs2,
  input  logic [AW-1:0]    in_rd,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  output logic             done,
  output logic [WIDTH-1:0] done_data,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             use_imm_q, use_imm_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic [AW-1:0]    rs1_q, rs1_d;
  logic [AW-1:0]    rs2_q, rs2_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [1:0]       alu_sel_q, alu_sel_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] done_data_q, done_data_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] rf_q [NREGS];
  logic [WIDTH-1:0] rf_d [NREGS];

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    use_imm_d   = use_imm_q;
    imm_d       = imm_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    result_d    = result_q;
    done_d      = 1'b0;
    done_data_d = done_data_q;
    rf_d        = rf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d      = in_op;
          use_imm_d = in_use_imm;
          imm_d     = in_imm;
          rs1_d     = in_rs1;
          rs2_d     = in_rs2;
          rd_d      = in_rd;
          state_d   = S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        alu_a_d   = use_imm_q ? imm_q : rf_q[rs1_q];
        alu_b_d   = rf_q[rs2_q];
        alu_sel_d = op_q;
        state_d   = S_EXEC;
      end
      S_EXEC: begin
        // done_data is loaded with done so it is valid for the whole pulse
        result_d    = alu_result;
        done_data_d = alu_result;
        done_d      = 1'b1;
        state_d     = S_WB;
      end
      S_WB: begin
        rf_d[rd_q] = result_q;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    in_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= 2'b00;
      use_imm_q   <= 1'b0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= 2'b00;
      result_q    <= '0;
      done_q      <= 1'b0;
      done_data_q <= '0;
      in_ready_q  <= 1'b1;
      rf_q        <= '{default: '0};
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      use_imm_q   <= use_imm_d;
      imm_q       <= imm_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      result_q    <= result_d;
      done_q      <= done_d;
      done_data_q <= done_data_d;
      in_ready_q  <= in_ready_d;
      rf_q        <= rf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign done      = done_q;
  assign done_data = done_data_q;
  assign dbg_data  = rf_q[dbg_addr];

`ifdef ALU_SEQ_FLAGS_EN
  logic             flag_z_q, flag_z_d;
  logic             flag_n_q, flag_n_d;
  logic             flag_c_q, flag_c_d;
  logic [WIDTH:0]   carry_sum;

  always_comb begin
    flag_z_d  = flag_z_q;
    flag_n_d  = flag_n_q;
    flag_c_d  = flag_c_q;
    carry_sum = {1'b0, alu_a_q} + {1'b0, alu_b_q};
    if (state_q == S_EXEC) begin
      flag_z_d = (alu_result == '0);
      flag_n_d = alu_result[WIDTH-1];
      case (alu_sel_q)
        2'b01:   flag_c_d = carry_sum[WIDTH];
        2'b10:   flag_c_d = (alu_a_q < alu_b_q);
        default: flag_c_d = 1'b0;
      endcase
    end else begin
      flag_c_d = flag_c_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      flag_z_q <= flag_z_d;
      flag_n_q <= flag_n_d;
      flag_c_q <= flag_c_d;
    end
  end

  assign flag_z = flag_z_q;
  assign flag_n = flag_n_q;
  assign flag_c = flag_c_q;
`else
  assign flag_z = 1'b0;
  assign flag_n = 1'b0;
  assign flag_c = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural model of the combinational ALU.
module tb_alu_op_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic        in_use_imm;
  logic [15:0] in_imm;
  logic [1:0]  in_rs1, in_rs2, in_rd;
  logic [15:0] alu_a, alu_b;
  logic [1:0]  alu_sel;
  logic [15:0] alu_result;
  logic        done;
  logic [15:0] done_data;
  logic [1:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic        flag_z, flag_n, flag_c;

  int checks = 0;
  int errors = 0;

  alu_op_sequencer #(.WIDTH(16), .NREGS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_use_imm(in_use_imm), .in_imm(in_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
    .done(done), .done_data(done_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c)
  );

  always #5 clk = ~clk;

  // ALU environment model
  always_comb begin
    case (alu_sel)
      2'b00:   alu_result = alu_a;
      2'b01:   alu_result = alu_a + alu_b;
      2'b10:   alu_result = alu_a - alu_b;
      default: alu_result = 16'h0000;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [1:0] a, output logic [15:0] v);
    dbg_addr = a;
    #1;
    v = dbg_data;
  endtask

  // Drives one instruction; reports tick index (accept tick = 1) of the done pulse and its data.
  task automatic send(input logic [1:0] op, input logic ui, input logic [15:0] imm,
                      input logic [1:0] rs1, input logic [1:0] rs2, input logic [1:0] rd,
                      output int dcyc, output logic [15:0] dd);
    dcyc = -1;
    dd = 16'h0000;
    for (int k = 0; k < 8; k++) begin
      if (in_ready) break;
      tick();
    end
    in_valid = 1'b1; in_op = op; in_use_imm = ui; in_imm = imm;
    in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    tick();
    in_valid = 1'b0;
    for (int k = 2; k <= 8; k++) begin
      tick();
      if (done && dcyc < 0) begin
        dcyc = k;
        dd = done_data;
      end
      if (in_ready) break;
    end
  endtask

  task automatic test_reset();
    logic [15:0] v;
    int dc;
    logic [15:0] dd;
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", in_ready); end
    checks++; if (done !== 1'b0 || done_data !== 16'h0000) begin errors++; $display("FAIL reset_done got %0b/%h want 0/0000", done, done_data); end
    checks++; if (alu_a !== 16'h0 || alu_b !== 16'h0 || alu_sel !== 2'b00) begin errors++; $display("FAIL reset_alu got %h %h %0d want 0 0 0", alu_a, alu_b, alu_sel); end
    send(2'b00, 1'b1, 16'h0007, 2'd0, 2'd0, 2'd1, dc, dd);
    // accept a second instruction and reset while it sits in READ
    in_valid = 1'b1; in_op = 2'b00; in_use_imm = 1'b1; in_imm = 16'h0009; in_rd = 2'd2;
    tick();
    in_valid = 1'b0;
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    checks++; if (in_ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL midread_reset got ready=%0b done=%0b want 1 0", in_ready, done); end
    for (int a = 0; a < 4; a++) begin
      peek(2'(a), v);
      checks++; if (v !== 16'h0000) begin errors++; $display("FAIL reset_rf[%0d] got %h want 0000", a, v); end
    end
    checks++; if (done_data !== 16'h0000 || flag_z !== 1'b0 || flag_n !== 1'b0 || flag_c !== 1'b0) begin
      errors++; $display("FAIL reset_data_flags got %h %0b%0b%0b want 0000 000", done_data, flag_z, flag_n, flag_c); end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_no_done got %0b want 0", done); end
    end
  endtask

  task automatic test_load_imm();
    int dc;
    logic [15:0] dd, v;
    send(2'b00, 1'b1, 16'h0005, 2'd0, 2'd0, 2'd1, dc, dd);
    checks++; if (dc !== 3 || dd !== 16'h0005) begin errors++; $display("FAIL li_r1 got tick=%0d data=%h want 3 0005", dc, dd); end
    send(2'b00, 1'b1, 16'h0003, 2'd0, 2'd0, 2'd2, dc, dd);
    checks++; if (dc !== 3 || dd !== 16'h0003) begin errors++; $display("FAIL li_r2 got tick=%0d data=%h want 3 0003", dc, dd); end
    checks++; if (done_data !== 16'h0003) begin errors++; $display("FAIL done_data_hold got %h want 0003", done_data); end
    peek(2'd1, v);
    checks++; if (v !== 16'h0005) begin errors++; $display("FAIL dbg_r1 got %h want 0005", v); end
    peek(2'd2, v);
    checks++; if (v !== 16'h0003) begin errors++; $display("FAIL dbg_r2 got %h want 0003", v); end
  endtask

  task automatic test_add_wrap();
    int dc;
    logic [15:0] dd, v;
    send(2'b01, 1'b1, 16'hFFFF, 2'd0, 2'd2, 2'd3, dc, dd);
    checks++; if (dd !== 16'h0002) begin errors++; $display("FAIL add_wrap got %h want 0002", dd); end
    checks++; if (alu_a !== 16'hFFFF || alu_b !== 16'h0003 || alu_sel !== 2'b01) begin
      errors++; $display("FAIL add_operands got %h %h %0d want ffff 0003 1", alu_a, alu_b, alu_sel); end
    peek(2'd3, v);
    checks++; if (v !== 16'h0002) begin errors++; $display("FAIL dbg_r3 got %h want 0002", v); end
`ifdef ALU_SEQ_FLAGS_EN
    checks++; if ({flag_z, flag_n, flag_c} !== 3'b001) begin errors++; $display("FAIL add_flags got %0b%0b%0b want 001", flag_z, flag_n, flag_c); end
`else
    checks++; if ({flag_z, flag_n, flag_c} !== 3'b000) begin errors++; $display("FAIL add_flags_off got %0b%0b%0b want 000", flag_z, flag_n, flag_c); end
`endif
  endtask

  task automatic test_sub_clear();
    int dc;
    logic [15:0] dd, v;
    send(2'b10, 1'b0, 16'h0000, 2'd2, 2'd1, 2'd0, dc, dd);
    checks++; if (dd !== 16'hFFFE) begin errors++; $display("FAIL sub got %h want fffe", dd); end
`ifdef ALU_SEQ_FLAGS_EN
    checks++; if ({flag_z, flag_n, flag_c} !== 3'b011) begin errors++; $display("FAIL sub_flags got %0b%0b%0b want 011", flag_z, flag_n, flag_c); end
`endif
    peek(2'd0, v);
    checks++; if (v !== 16'hFFFE) begin errors++; $display("FAIL dbg_r0_sub got %h want fffe", v); end
    send(2'b11, 1'b0, 16'h0000, 2'd0, 2'd0, 2'd0, dc, dd);
    peek(2'd0, v);
    checks++; if (dd !== 16'h0000 || v !== 16'h0000) begin errors++; $display("FAIL clear got %h/%h want 0000/0000", dd, v); end
`ifdef ALU_SEQ_FLAGS_EN
    checks++; if ({flag_z, flag_n, flag_c} !== 3'b100) begin errors++; $display("FAIL clear_flags got %0b%0b%0b want 100", flag_z, flag_n, flag_c); end
`endif
  endtask

  task automatic test_valid_held();
    int acc_t[3];
    int n_acc = 0, n_low = 0, n_done = 0;
    logic [15:0] v;
    logic [15:0] imms[3];
    imms[0] = 16'h0011; imms[1] = 16'h0022; imms[2] = 16'h0033;
    acc_t[0] = -1; acc_t[1] = -1; acc_t[2] = -1;
    in_valid = 1'b1; in_op = 2'b00; in_use_imm = 1'b1; in_imm = imms[0]; in_rd = 2'd0;
    for (int t = 1; t <= 12; t++) begin
      logic acc;
      acc = in_valid && in_ready;
      tick();
      if (acc && n_acc < 3) begin
        acc_t[n_acc] = t;
        n_acc++;
        if (n_acc < 3) begin
          in_imm = imms[n_acc];
          in_rd = 2'(n_acc);
        end
      end
      if (!in_ready) n_low++;
      if (done) n_done++;
    end
    in_valid = 1'b0;
    checks++; if (acc_t[0] !== 1 || acc_t[1] !== 5 || acc_t[2] !== 9) begin
      errors++; $display("FAIL held_accepts got %0d %0d %0d want 1 5 9", acc_t[0], acc_t[1], acc_t[2]); end
    checks++; if (n_low !== 9 || n_done !== 3) begin errors++; $display("FAIL held_ready_done got low=%0d done=%0d want 9 3", n_low, n_done); end
    peek(2'd2, v);
    checks++; if (v !== 16'h0033) begin errors++; $display("FAIL held_r2 got %h want 0033", v); end
    peek(2'd3, v);
    checks++; if (v !== 16'h0002) begin errors++; $display("FAIL held_r3_untouched got %h want 0002", v); end
  endtask

  task automatic test_back_to_back();
    int dc;
    logic [15:0] dd, v;
    send(2'b00, 1'b1, 16'h0005, 2'd0, 2'd0, 2'd1, dc, dd);
    send(2'b01, 1'b0, 16'h0000, 2'd1, 2'd1, 2'd1, dc, dd);
    checks++; if (dd !== 16'h000A) begin errors++; $display("FAIL dep_add1 got %h want 000a", dd); end
    send(2'b01, 1'b0, 16'h0000, 2'd1, 2'd1, 2'd1, dc, dd);
    checks++; if (dd !== 16'h0014) begin errors++; $display("FAIL dep_add2 got %h want 0014", dd); end
    peek(2'd1, v);
    checks++; if (v !== 16'h0014) begin errors++; $display("FAIL dep_r1 got %h want 0014", v); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_use_imm = 1'b0; in_imm = 16'h0000;
    in_rs1 = 2'd0; in_rs2 = 2'd0; in_rd = 2'd0; dbg_addr = 2'd0;
    test_reset();
    test_load_imm();
    test_add_wrap();
    test_sub_clear();
    test_valid_held();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
